// File: rtl/uart_frame_scheduler.sv
// Decimates video beats into 32-bit words, round-robins them against a status word,
// and serialises the winner as a 5-byte header-plus-data frame paced by tready.
module uart_frame_scheduler #(
  parameter int unsigned DECIM    = 1024,
  parameter logic [7:0]  HDR_VID  = 8'hA5,
  parameter logic [7:0]  HDR_STAT = 8'h5A
) (
  input  logic        axi_stream_aclk,
  input  logic        rst_n,
  input  logic        vid_tvalid,
  input  logic [31:0] vid_tdata,
  input  logic        stat_valid,
  input  logic [31:0] stat_data,
  output logic        stat_ready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  // DECIM=1 still needs a 1-bit counter that simply stays at zero.
  localparam int unsigned     DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

  typedef enum logic {IDLE, SEND} state_e;
  typedef enum logic {SRC_VID, SRC_STAT} src_e;

  state_e           state_q, state_d;
  src_e             grant_q, grant_d;
  src_e             last_grant_q, last_grant_d;
  logic [2:0]       idx_q, idx_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [31:0]      vid_buf_q, vid_buf_d;
  logic             vid_full_q, vid_full_d;
  logic [31:0]      stat_buf_q, stat_buf_d;
  logic             stat_full_q, stat_full_d;
  logic             stat_ready_q, stat_ready_d;
  logic [15:0]      drop_q, drop_d;

  logic        byte_acc;
  logic        last_byte;
  logic        rel_vid;
  logic        rel_stat;
  logic        capture;
  logic        cap_ok;
  logic [31:0] word_sel;
  logic [7:0]  hdr_sel;
  logic [7:0]  byte_sel;

  assign byte_acc  = (state_q == SEND) && m_axis_tready;
  assign last_byte = (idx_q == 3'd4);
  assign rel_vid   = byte_acc && last_byte && (grant_q == SRC_VID);
  assign rel_stat  = byte_acc && last_byte && (grant_q == SRC_STAT);
  assign capture   = vid_tvalid && (dec_cnt_q == DEC_LAST);
  // A capture landing on the release cycle refills the buffer instead of dropping.
  assign cap_ok    = !vid_full_q || rel_vid;

  always_ff @(posedge axi_stream_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= SRC_VID;
      last_grant_q <= SRC_STAT;
      idx_q        <= 3'd0;
      dec_cnt_q    <= '0;
      vid_buf_q    <= 32'h0;
      vid_full_q   <= 1'b0;
      stat_buf_q   <= 32'h0;
      stat_full_q  <= 1'b0;
      stat_ready_q <= 1'b0;
      drop_q       <= 16'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      dec_cnt_q    <= dec_cnt_d;
      vid_buf_q    <= vid_buf_d;
      vid_full_q   <= vid_full_d;
      stat_buf_q   <= stat_buf_d;
      stat_full_q  <= stat_full_d;
      stat_ready_q <= stat_ready_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    dec_cnt_d   = dec_cnt_q;
    vid_buf_d   = vid_buf_q;
    vid_full_d  = vid_full_q;
    stat_buf_d  = stat_buf_q;
    stat_full_d = stat_full_q;
    drop_d      = drop_q;

    if (vid_tvalid) begin
      dec_cnt_d = capture ? '0 : dec_cnt_q + DEC_W'(1);
    end
    if (rel_vid) begin
      vid_full_d = 1'b0;
    end
    if (capture) begin
      if (cap_ok) begin
        vid_buf_d  = vid_tdata;
        vid_full_d = 1'b1;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end

    if (rel_stat) begin
      stat_full_d = 1'b0;
    end
    if (stat_valid && stat_ready_q) begin
      stat_buf_d  = stat_data;
      stat_full_d = 1'b1;
    end
    stat_ready_d = !stat_full_d;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;

    case (state_q)
      IDLE: begin
        if (vid_full_q || stat_full_q) begin
          if (vid_full_q && stat_full_q) begin
            grant_d = (last_grant_q == SRC_STAT) ? SRC_VID : SRC_STAT;
          end else begin
            grant_d = vid_full_q ? SRC_VID : SRC_STAT;
          end
          last_grant_d = grant_d;
          idx_d        = 3'd0;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (last_byte) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    word_sel = (grant_q == SRC_VID) ? vid_buf_q : stat_buf_q;
    hdr_sel  = (grant_q == SRC_VID) ? HDR_VID : HDR_STAT;
    case (idx_q)
      3'd0:    byte_sel = hdr_sel;
      3'd1:    byte_sel = word_sel[7:0];
      3'd2:    byte_sel = word_sel[15:8];
      3'd3:    byte_sel = word_sel[23:16];
      3'd4:    byte_sel = word_sel[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = (state_q == SEND) ? byte_sel : 8'h00;
  assign busy          = (state_q == SEND);
  assign stat_ready    = stat_ready_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: one DECIM=4 and one DECIM=1 instance share stimulus,
// each test resets both and checks only the instance it targets.
module tb_uart_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vidTvalid;
  logic [31:0] vidTdata;
  logic        statValid;
  logic [31:0] statData;
  logic        tready;

  logic        statReady4, tvalid4, busy4;
  logic [7:0]  tdata4;
  logic [15:0] drop4;
  logic        statReady1, tvalid1, busy1;
  logic [7:0]  tdata1;
  logic [15:0] drop1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vv;
    logic [31:0] vd;
    logic        sv;
    logic [31:0] sd;
    logic        tr;
    logic        tv;
    logic [7:0]  td;
    logic        sr;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  uart_frame_scheduler #(.DECIM(4)) dut4 (
    .axi_stream_aclk(clk), .rst_n(rst_n),
    .vid_tvalid(vidTvalid), .vid_tdata(vidTdata),
    .stat_valid(statValid), .stat_data(statData), .stat_ready(statReady4),
    .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4), .m_axis_tready(tready),
    .drop_cnt(drop4), .busy(busy4)
  );

  uart_frame_scheduler #(.DECIM(1)) dut1 (
    .axi_stream_aclk(clk), .rst_n(rst_n),
    .vid_tvalid(vidTvalid), .vid_tdata(vidTdata),
    .stat_valid(statValid), .stat_data(statData), .stat_ready(statReady1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
    .drop_cnt(drop1), .busy(busy1)
  );

  task automatic applyStimulus(input logic vv, input logic [31:0] vd, input logic sv,
                               input logic [31:0] sd, input logic tr);
    vidTvalid = vv;
    vidTdata  = vd;
    statValid = sv;
    statData  = sd;
    tready    = tr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Busy and tvalid both mean "in SEND", so one expected bit covers both.
  task automatic checkBus(input bit d1, input string tag, input logic tv,
                          input logic [7:0] td, input logic sr);
    checkOutput({tag, ".tvalid"}, 32'(d1 ? tvalid1 : tvalid4), 32'(tv));
    checkOutput({tag, ".tdata"}, 32'(d1 ? tdata1 : tdata4), 32'(td));
    checkOutput({tag, ".busy"}, 32'(d1 ? busy1 : busy4), 32'(tv));
    checkOutput({tag, ".stat_ready"}, 32'(d1 ? statReady1 : statReady4), 32'(sr));
  endtask

  function automatic vec_t mkRow(input logic vv, input logic [31:0] vd, input logic sv,
                                 input logic [31:0] sd, input logic tr, input logic tv,
                                 input logic [7:0] td, input logic sr);
    vec_t v;
    v.vv = vv; v.vd = vd; v.sv = sv; v.sd = sd;
    v.tr = tr; v.tv = tv; v.td = td; v.sr = sr;
    return v;
  endfunction

  function automatic vec_t idleRow(input logic sr);
    return mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, sr);
  endfunction

  task automatic addFrame(input logic [7:0] hdr, input logic [31:0] w, input logic sr);
    vq.push_back(mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, hdr, sr));
    for (int b = 0; b < 4; b++) begin
      vq.push_back(mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, w[8*b +: 8], sr));
    end
  endtask

  // n idle-bus video beats; the last one carries the word that should be captured.
  task automatic addBeats(input int n, input logic [31:0] last, input logic firstSr);
    for (int i = 0; i < n; i++) begin
      vq.push_back(mkRow(1'b1, (i == n - 1) ? last : 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00,
                         (i == 0) ? firstSr : 1'b1));
    end
  endtask

  task automatic runVectors(input bit d1, input string tname);
    foreach (vq[i]) begin
      @(negedge clk);
      applyStimulus(vq[i].vv, vq[i].vd, vq[i].sv, vq[i].sd, vq[i].tr);
      checkBus(d1, $sformatf("%s[%0d]", tname, i), vq[i].tv, vq[i].td, vq[i].sr);
    end
    vq.delete();
  endtask

  // Release lands mid high-phase so the next negedge is the first post-reset cycle.
  task automatic doReset(input bit d1, input string tag);
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    checkBus(d1, {tag, ".rst"}, 1'b0, 8'h00, 1'b0);
    checkOutput({tag, ".rst.drop"}, 32'(d1 ? drop1 : drop4), 32'h0);
    repeat (2) @(negedge clk);
    checkBus(d1, {tag, ".rsthold"}, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t t;
    logic [31:0] w;
    logic        expTv;
    logic [7:0]  expTd;
    int          k, pos, expDrop;

    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;

    // Video frames from the 4th and 8th beats, then a status frame.
    doReset(1'b0, "t1");
    addBeats(4, 32'h14253647, 1'b0);
    vq.push_back(idleRow(1'b1));
    addFrame(8'hA5, 32'h14253647, 1'b1);
    addBeats(4, 32'h18293A4B, 1'b1);
    vq.push_back(idleRow(1'b1));
    addFrame(8'hA5, 32'h18293A4B, 1'b1);
    vq.push_back(idleRow(1'b1));
    vq.push_back(mkRow(1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 1'b1));
    vq.push_back(idleRow(1'b0));
    addFrame(8'h5A, 32'hDEADBEEF, 1'b0);
    vq.push_back(idleRow(1'b1));
    runVectors(1'b0, "t1");
    checkOutput("t1.drop", 32'(drop4), 32'h0);

    // Both buffers fill on the same edge after reset: video wins the first tie.
    doReset(1'b0, "t3");
    addBeats(3, 32'h0, 1'b0);
    vq.push_back(mkRow(1'b1, 32'h0A0B0C0D, 1'b1, 32'h50515253, 1'b1, 1'b0, 8'h00, 1'b1));
    vq.push_back(idleRow(1'b0));
    addFrame(8'hA5, 32'h0A0B0C0D, 1'b0);
    vq.push_back(idleRow(1'b0));
    addFrame(8'h5A, 32'h50515253, 1'b0);
    vq.push_back(idleRow(1'b1));
    runVectors(1'b0, "t3");

    // Video granted last, video refilled on its release edge with status waiting: status wins.
    doReset(1'b1, "t3b");
    vq.push_back(mkRow(1'b1, 32'h0D0D0D0D, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00, 1'b0));
    vq.push_back(mkRow(1'b0, 32'h0, 1'b1, 32'h77665544, 1'b1, 1'b0, 8'h00, 1'b1));
    addFrame(8'hA5, 32'h0D0D0D0D, 1'b0);
    t = vq.pop_back();
    t.vv = 1'b1;
    t.vd = 32'hEEEEEEEE;
    vq.push_back(t);
    vq.push_back(idleRow(1'b0));
    addFrame(8'h5A, 32'h77665544, 1'b0);
    vq.push_back(idleRow(1'b1));
    addFrame(8'hA5, 32'hEEEEEEEE, 1'b1);
    vq.push_back(idleRow(1'b1));
    runVectors(1'b1, "t3b");
    checkOutput("t3b.drop", 32'(drop1), 32'h0);

    // Backpressure on the second data byte for 10 cycles.
    doReset(1'b0, "t4");
    addBeats(4, 32'hCAFEF00D, 1'b0);
    vq.push_back(idleRow(1'b1));
    vq.push_back(mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hA5, 1'b1));
    vq.push_back(mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h0D, 1'b1));
    for (int i = 0; i < 10; i++) begin
      vq.push_back(mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 8'hF0, 1'b1));
    end
    vq.push_back(mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hF0, 1'b1));
    vq.push_back(mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hFE, 1'b1));
    vq.push_back(mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hCA, 1'b1));
    vq.push_back(idleRow(1'b1));
    runVectors(1'b0, "t4");

    // Reset at idx 3 with the decimator part-way through its next word.
    doReset(1'b0, "t6");
    addBeats(4, 32'h44332211, 1'b0);
    vq.push_back(idleRow(1'b1));
    vq.push_back(mkRow(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8'hA5, 1'b1));
    vq.push_back(mkRow(1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h11, 1'b1));
    vq.push_back(mkRow(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 8'h22, 1'b1));
    runVectors(1'b0, "t6a");
    @(negedge clk);
    checkBus(1'b0, "t6.idx3", 1'b1, 8'h33, 1'b1);
    doReset(1'b0, "t6mid");
    addBeats(4, 32'h0F0E0D0C, 1'b0);
    vq.push_back(idleRow(1'b1));
    addFrame(8'hA5, 32'h0F0E0D0C, 1'b1);
    vq.push_back(idleRow(1'b1));
    runVectors(1'b0, "t6b");
    checkOutput("t6.drop", 32'(drop4), 32'h0);

    // DECIM=1 with a beat every cycle: 6-cycle frames, 5 drops per frame.
    doReset(1'b1, "t5");
    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      applyStimulus(1'b1, 32'hA0000000 | 32'(r), 1'b0, 32'h0, 1'b1);
      expTv = 1'b0;
      expTd = 8'h00;
      if (r >= 2) begin
        k   = (r - 2) / 6;
        pos = (r - 2) % 6;
        w   = 32'hA0000000 | 32'(6 * k);
        if (pos == 0) begin
          expTv = 1'b1;
          expTd = 8'hA5;
        end else if (pos < 5) begin
          expTv = 1'b1;
          expTd = w[8*(pos-1) +: 8];
        end
      end
      expDrop = 0;
      for (int e = 2; e <= r; e++) begin
        if ((e - 1) % 6 != 0) expDrop++;
      end
      checkOutput($sformatf("t5[%0d].tvalid", r), 32'(tvalid1), 32'(expTv));
      checkOutput($sformatf("t5[%0d].tdata", r), 32'(tdata1), 32'(expTd));
      checkOutput($sformatf("t5[%0d].drop", r), 32'(drop1), 32'(expDrop));
    end
    @(negedge clk);
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (65600) @(negedge clk);
    checkOutput("t5.sat.drop", 32'(drop1), 32'h0000FFFF);
    checkOutput("t5.sat.tvalid", 32'(tvalid1), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
